// File: rtl/fifo_rd_streamer_pkg.sv
// fifo_rd_streamer_pkg: shared types and widths for the FIFO read streamer.
package fifo_rd_streamer_pkg;
   localparam int DATA_W = 32;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2, DRAIN = 2'd3} state_e;
endpackage

// File: rtl/fifo_rd_streamer_skid_buf.sv
// fifo_rd_streamer_skid_buf: 2-entry in-order buffer of {last,data} words.
module fifo_rd_streamer_skid_buf #(
   parameter int W = 33
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_push,
   input  logic         i_pop,
   input  logic [W-1:0] i_data,
   output logic [W-1:0] o_head,
   output logic [1:0]   o_occ
);
   logic [W-1:0] r_mem [2];
   logic         r_wr_ptr, r_rd_ptr;
   logic [1:0]   r_occ;

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_occ    <= 2'd0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= !r_wr_ptr;
         end
         if (i_pop) r_rd_ptr <= !r_rd_ptr;
         r_occ <= r_occ + {1'b0, i_push} - {1'b0, i_pop};
      end

   assign o_head = r_mem[r_rd_ptr];
   assign o_occ  = r_occ;
endmodule

// File: rtl/fifo_rd_streamer.sv
// fifo_rd_streamer: drains a 1-cycle-latency sync FIFO into a packetised valid/ready stream.
module fifo_rd_streamer #(
   parameter int DATA_W  = fifo_rd_streamer_pkg::DATA_W,
   parameter int PKT_LEN = 16,
   parameter int CNT_W   = 16
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_en,
   output logic              o_fifo_rd_en,
   input  logic [DATA_W-1:0] i_fifo_rd_data,
   input  logic              i_fifo_empty,
   output logic              o_m_valid,
   input  logic              i_m_ready,
   output logic [DATA_W-1:0] o_m_data,
   output logic              o_m_last,
   output logic [CNT_W-1:0]  o_pkt_cnt,
   output logic              o_busy
);
   import fifo_rd_streamer_pkg::*;

   localparam int IW = $clog2(PKT_LEN);
   localparam logic [IW-1:0] LAST_IDX = IW'(PKT_LEN - 1);

   state_e            r_state, w_next;
   logic              r_inflight, r_inflight_last;
   logic [IW-1:0]     r_issue_cnt, r_beat_cnt;
   logic [CNT_W-1:0]  r_pkt_cnt;
   logic [1:0]        w_occ;
   logic [DATA_W:0]   w_head;
   logic [DATA_W-1:0] w_data;
   logic              w_last_tag, w_valid, w_pop, w_push, w_issue_ok;

   // The word returning from the FIFO bypasses the buffer when it is empty,
   // so a read at cycle N is presented at N+1.
   assign w_valid               = (w_occ != 2'd0) || r_inflight;
   assign {w_last_tag, w_data}  = (w_occ != 2'd0) ? w_head : {r_inflight_last, i_fifo_rd_data};
   assign w_pop                 = w_valid && i_m_ready;
   assign w_push                = r_inflight && !((w_occ == 2'd0) && w_pop);
   assign w_issue_ok            = (r_state == RUN) || ((r_state == STOP) && (r_issue_cnt != '0));
   assign o_fifo_rd_en          = w_issue_ok && !i_fifo_empty &&
                                  (({1'b0, w_occ} + {2'b0, r_inflight} - {2'b0, w_pop}) < 3'd2);

   assign o_m_valid = w_valid;
   assign o_m_data  = w_valid ? w_data : '0;
   assign o_m_last  = w_valid && w_last_tag;
   assign o_pkt_cnt = r_pkt_cnt;
   assign o_busy    = (r_state != IDLE) || w_valid;

   always_comb
      w_next = (r_state == IDLE) ? (i_en ? RUN : IDLE) :
               (r_state == RUN)  ? (i_en ? RUN : STOP) :
               i_en              ? RUN :
               (r_state == STOP) ? ((r_issue_cnt == '0) ? DRAIN : STOP) :
               (w_valid ? DRAIN : IDLE);

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_state         <= IDLE;
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
         r_issue_cnt     <= '0;
         r_beat_cnt      <= '0;
         r_pkt_cnt       <= '0;
      end else begin
         r_state    <= w_next;
         r_inflight <= o_fifo_rd_en;
         if (o_fifo_rd_en) begin
            r_inflight_last <= (r_issue_cnt == LAST_IDX);
            r_issue_cnt     <= (r_issue_cnt == LAST_IDX) ? '0 : r_issue_cnt + 1'b1;
         end
         if (w_pop) r_beat_cnt <= (r_beat_cnt == LAST_IDX) ? '0 : r_beat_cnt + 1'b1;
         if (w_pop && o_m_last) r_pkt_cnt <= r_pkt_cnt + 1'b1;
      end

   fifo_rd_streamer_skid_buf #(.W(DATA_W + 1)) u_skid (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop && (w_occ != 2'd0)),
      .i_data  ({r_inflight_last, i_fifo_rd_data}),
      .o_head  (w_head),
      .o_occ   (w_occ)
   );
endmodule

// File: tb/tb_fifo_rd_streamer.sv
// tb_fifo_rd_streamer: directed bench with a behavioural sync FIFO and an in-order scoreboard.
module tb_fifo_rd_streamer;
   logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, m_ready = 1'b0, fifo_empty = 1'b1;
   logic [31:0] fifo_rd_data = '0;
   logic        fifo_rd_en, m_valid, m_last, busy;
   logic [31:0] m_data;
   logic [3:0]  pkt_cnt;

   int          errors = 0, checks = 0, i = 0, first_hs = -1, last_hs = -1, cyc = 0;
   int unsigned beat_idx = 0, beats = 0, reads = 0, r0 = 0;
   logic [31:0] wr_val = '0, exp_next = '0;
   logic [31:0] q[$];

   fifo_rd_streamer #(.PKT_LEN(16), .CNT_W(4)) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_en           (en),
      .o_fifo_rd_en   (fifo_rd_en),
      .i_fifo_rd_data (fifo_rd_data),
      .i_fifo_empty   (fifo_empty),
      .o_m_valid      (m_valid),
      .i_m_ready      (m_ready),
      .o_m_data       (m_data),
      .o_m_last       (m_last),
      .o_pkt_cnt      (pkt_cnt),
      .o_busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic load(input int n);
      repeat (n) begin
         q.push_back(wr_val);
         wr_val++;
      end
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while (busy && k < 100) begin
         tick(1);
         k++;
      end
      chk({tag, " idle"}, 64'(busy), 64'd0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " rd_en"}, 64'(fifo_rd_en), 64'd0);
      chk({tag, " m_valid"}, 64'(m_valid), 64'd0);
      chk({tag, " m_data"}, 64'(m_data), 64'd0);
      chk({tag, " m_last"}, 64'(m_last), 64'd0);
      chk({tag, " pkt_cnt"}, 64'(pkt_cnt), 64'd0);
      chk({tag, " busy"}, 64'(busy), 64'd0);
   endtask

   // Sync FIFO model: data one clock after rd_en, registered empty flag.
   always @(posedge clk) begin
      cyc++;
      if (rst_n && fifo_rd_en) begin
         reads++;
         checks++;
         assert (q.size() != 0) else begin
            errors++;
            $error("FAIL underflow: got read with %0d words expected none", q.size());
         end
         if (q.size() != 0) fifo_rd_data <= q.pop_front();
      end
      fifo_empty <= (q.size() == 0);
   end

   // Beats seen at the negedge complete on the following posedge.
   always @(negedge clk)
      if (rst_n) begin
         chk("outstanding<=2", 64'((reads - beats) <= 2), 64'd1);
         if (m_valid && m_ready) begin
            chk("beat data", 64'(m_data), 64'(exp_next));
            chk("beat last", 64'(m_last), 64'((beat_idx % 16) == 15));
            exp_next++;
            beat_idx++;
            beats++;
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
         end
      end

   initial begin
      #1;
      chk_zero("reset");
      tick(2);
      rst_n = 1'b1;
      tick(1);
      chk("post-reset m_valid", 64'(m_valid), 64'd0);

      // Full-rate streaming of 0..31
      load(32);
      tick(1);
      en = 1'b1;
      m_ready = 1'b1;
      tick(1);
      chk("t2 rd_en cycle1", 64'(fifo_rd_en), 64'd1);
      chk("t2 m_valid cycle1", 64'(m_valid), 64'd0);
      tick(1);
      chk("t2 m_valid cycle2", 64'(m_valid), 64'd1);
      chk("t2 first data", 64'(m_data), 64'd0);
      tick(40);
      chk("t2 beats", 64'(beats), 64'd32);
      chk("t2 back-to-back", 64'(last_hs - first_hs), 64'd31);
      chk("t2 pkt_cnt", 64'(pkt_cnt), 64'd2);
      en = 1'b0;
      wait_idle("t2");
      chk("t2 reads", 64'(reads), 64'd32);

      // Random backpressure, 64 words
      load(64);
      tick(1);
      en = 1'b1;
      i = 0;
      while (beats < 96 && i < 1000) begin
         m_ready = 1'($urandom_range(0, 1));
         tick(1);
         i++;
      end
      m_ready = 1'b1;
      chk("t3 beats", 64'(beats), 64'd96);
      chk("t3 pkt_cnt", 64'(pkt_cnt), 64'd6);
      en = 1'b0;
      wait_idle("t3");

      // Stop after 5 reads: the packet still completes with exactly 16 pops
      load(40);
      tick(1);
      r0 = reads;
      en = 1'b1;
      i = 0;
      while (reads - r0 < 5 && i < 50) begin
         tick(1);
         i++;
      end
      en = 1'b0;
      wait_idle("t4");
      chk("t4 reads", 64'(reads - r0), 64'd16);
      chk("t4 fifo left", 64'(q.size()), 64'd24);
      chk("t4 beats", 64'(beats), 64'd112);
      chk("t4 pkt_cnt", 64'(pkt_cnt), 64'd7);
      q.delete();
      exp_next = wr_val;
      tick(1);

      // Empty mid-packet: stall without m_last, resume when refilled
      load(10);
      tick(1);
      en = 1'b1;
      tick(20);
      chk("t5 beats partial", 64'(beats), 64'd122);
      chk("t5 stalled m_valid", 64'(m_valid), 64'd0);
      chk("t5 stalled busy", 64'(busy), 64'd1);
      chk("t5 pkt_cnt partial", 64'(pkt_cnt), 64'd7);
      load(6);
      tick(15);
      chk("t5 beats", 64'(beats), 64'd128);
      chk("t5 pkt_cnt", 64'(pkt_cnt), 64'd8);
      en = 1'b0;
      wait_idle("t5");

      // Fill the buffer under backpressure, then reset asynchronously
      load(20);
      tick(1);
      r0 = reads;
      en = 1'b1;
      m_ready = 1'b0;
      tick(5);
      chk("t6 reads held", 64'(reads - r0), 64'd2);
      chk("t6 m_valid", 64'(m_valid), 64'd1);
      chk("t6 rd_en", 64'(fifo_rd_en), 64'd0);
      chk("t6 head data", 64'(m_data), 64'(exp_next));
      rst_n = 1'b0;
      #1;
      chk_zero("t6 async reset");
      q.delete();
      exp_next = wr_val;
      beat_idx = 0;
      beats = 0;
      reads = 0;
      m_ready = 1'b1;
      load(240);
      tick(2);
      rst_n = 1'b1;
      tick(1);
      chk("t6 m_valid after release", 64'(m_valid), 64'd0);
      chk("t6 rd_en after release", 64'(fifo_rd_en), 64'd1);
      tick(1);
      chk("t6 m_valid restart", 64'(m_valid), 64'd1);

      // pkt_cnt wrap with a 4-bit counter
      tick(260);
      chk("t7 beats 15 pkts", 64'(beats), 64'd240);
      chk("t7 pkt_cnt 15", 64'(pkt_cnt), 64'd15);
      load(16);
      tick(25);
      chk("t7 pkt_cnt wrap 0", 64'(pkt_cnt), 64'd0);
      load(16);
      tick(25);
      chk("t7 pkt_cnt 1", 64'(pkt_cnt), 64'd1);
      chk("t7 beats", 64'(beats), 64'd272);
      en = 1'b0;
      wait_idle("t7");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
